timer_slave: RTL

Memory-mapped machine timer that answers bus accesses in the timer window at 0x4000_4000 (slave 2 of the bus interconnect). Holds a 64-bit free-running `mtime` counter with programmable prescaler and a 64-bit `mtimecmp` compare register, and drives a registered timer interrupt to the core. Every access completes with a fixed one-wait-state ready handshake.

---
 rtl/timer_slave_if.sv | 12 +
 rtl/timer_slave.sv | 104 ++++++++++
 2 files changed

// File: rtl/timer_slave_if.sv
// timer_slave_if: bus signals between the interconnect and the machine timer
interface timer_slave_if;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_write;
    logic        s_enable;
    logic [31:0] s_rdata;
    logic        s_ready;
    modport master (output s_addr, s_wdata, s_wstrb, s_write, s_enable, input s_rdata, s_ready);
    modport slave  (input s_addr, s_wdata, s_wstrb, s_write, s_enable, output s_rdata, s_ready);
endinterface

// File: rtl/timer_slave.sv
// timer_slave: 64-bit mtime/mtimecmp machine timer with prescaler, one-wait-state bus slave; TIMER_SNAPSHOT_EN adds a tear-free MTIME_HI shadow
module timer_slave #(
    parameter logic [7:0] PRESCALE_RESET = 8'd0,
    parameter logic       EN_RESET       = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_slave_if.slave    bus,
    output logic            timer_irq
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t      state, state_nx;
    logic        acc, rd, tick, en;
    logic [2:0]  idx;
    logic [7:0]  wr_sel, pcnt, prescale;
    logic [63:0] mtime, mtimecmp, mtime_inc;
    logic [31:0] rd_val, rdata_q, mtime_hi_rd;
    logic        unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = st[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign unused_addr = ^{bus.s_addr[31:5], bus.s_addr[1:0]};
    assign idx         = bus.s_addr[4:2];
    assign wr_sel      = (acc && bus.s_write) ? (8'd1 << idx) : 8'd0;
    assign rd          = acc && !bus.s_write;
    assign tick        = en && (pcnt == prescale);
    assign mtime_inc   = mtime + {63'd0, tick};
    assign bus.s_ready = (state == RESP);
    assign bus.s_rdata = rdata_q;

    // handshake state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // accept a request only in IDLE; RESP always falls back to IDLE
    always_comb begin
        acc      = (state == IDLE) && bus.s_enable;
        state_nx = acc ? RESP : IDLE;
    end

    // prescaler and mtime; bus-written bytes override the incremented value
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pcnt  <= '0;
            mtime <= '0;
        end else begin
            pcnt  <= wr_sel[4] ? 8'd0 : (!en ? pcnt : (tick ? 8'd0 : pcnt + 8'd1));
            mtime <= {wr_sel[1] ? merge(mtime_inc[63:32], bus.s_wdata, bus.s_wstrb) : mtime_inc[63:32],
                      wr_sel[0] ? merge(mtime_inc[31:0],  bus.s_wdata, bus.s_wstrb) : mtime_inc[31:0]};
        end

    // compare and control registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mtimecmp <= '1;
            en       <= EN_RESET;
            prescale <= PRESCALE_RESET;
        end else begin
            if (wr_sel[2]) mtimecmp[31:0]  <= merge(mtimecmp[31:0],  bus.s_wdata, bus.s_wstrb);
            if (wr_sel[3]) mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.s_wdata, bus.s_wstrb);
            if (wr_sel[4] && bus.s_wstrb[0]) en       <= bus.s_wdata[0];
            if (wr_sel[4] && bus.s_wstrb[1]) prescale <= bus.s_wdata[15:8];
        end

    // registered interrupt, independent of en
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) timer_irq <= 1'b0;
        else        timer_irq <= (mtime >= mtimecmp);

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] shadow;
    // latch the upper half whenever the lower half is read
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                   shadow <= '0;
        else if (rd && idx == 3'd0)   shadow <= mtime[63:32];
    assign mtime_hi_rd = shadow;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    // read mux over the pre-edge register state
    always_comb begin
        rd_val = '0;
        case (idx)
            3'd0:    rd_val = mtime[31:0];
            3'd1:    rd_val = mtime_hi_rd;
            3'd2:    rd_val = mtimecmp[31:0];
            3'd3:    rd_val = mtimecmp[63:32];
            3'd4:    rd_val = {16'd0, prescale, 7'd0, en};
            3'd5:    rd_val = {31'd0, timer_irq};
            default: rd_val = '0;
        endcase
    end

    // read data is held for the RESP cycle only and is zero otherwise
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rd ? rd_val : 32'd0;
endmodule
